// File: rtl/iv_cmd_decoder.sv
// Decodes 8X305 IV-bus SC command bytes into a device/RAM address, an escape-
// prefixed page register, registered select flags and a saturating load counter.
module iv_cmd_decoder #(
    parameter int          PAGE_W = 4,
    parameter logic [7:0]  ESC    = 8'hFE,
    parameter int          CNT_W  = 16
) (
    input  logic                  cmd_clk,
    input  logic                  rst,
    input  logic [7:0]            cmd_in,
    output logic [7:0]            addr,
    output logic [PAGE_W-1:0]     page,
    output logic [PAGE_W+7:0]     full_addr,
    output logic                  sel_in,
    output logic                  sel_op1,
    output logic                  sel_op2,
    output logic                  sel_ram,
    output logic                  esc_pending,
    output logic                  addr_upd,
    output logic                  page_upd,
    output logic [CNT_W-1:0]      cmd_count
);

    typedef enum logic {
        IDLE = 1'b0,
        PAGE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                addr_upd_q, addr_upd_d;
    logic                page_upd_q, page_upd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load_addr;

    always_ff @(posedge cmd_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 8'hFF;
            page_q     <= '0;
            addr_upd_q <= 1'b0;
            page_upd_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            page_q     <= page_d;
            addr_upd_q <= addr_upd_d;
            page_upd_q <= page_upd_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        page_d     = page_q;
        page_upd_d = 1'b0;
        load_addr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_in == ESC) begin
                    state_d = PAGE;
                end else begin
                    load_addr = 1'b1;
                end
            end
            PAGE: begin
                state_d = IDLE;
                // A second ESC is a literal address byte, not a page value.
                if (cmd_in == ESC) begin
                    load_addr = 1'b1;
                end else begin
                    page_d     = cmd_in[PAGE_W-1:0];
                    page_upd_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        addr_upd_d = load_addr;
        cnt_d      = cnt_q;
        if (load_addr) begin
            addr_d = cmd_in;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign addr        = addr_q;
    assign page        = page_q;
    assign full_addr   = {page_q, addr_q};
    assign sel_in      = addr_q[7];
    assign sel_op1     = addr_q[5];
    assign sel_op2     = addr_q[6];
    assign sel_ram     = ~addr_q[7];
    assign esc_pending = (state_q == PAGE);
    assign addr_upd    = addr_upd_q;
    assign page_upd    = page_upd_q;
    assign cmd_count   = cnt_q;

endmodule

// File: tb/tb_iv_cmd_decoder.sv
// Directed bench for iv_cmd_decoder: default instance plus a CNT_W=4 instance
// sharing the same command stream for the saturation check.
module tb_iv_cmd_decoder;

    logic        cmd_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [7:0]  cmd_in  = 8'h00;

    logic [7:0]  addr;
    logic [3:0]  page;
    logic [11:0] full_addr;
    logic        sel_in, sel_op1, sel_op2, sel_ram, esc_pending, addr_upd, page_upd;
    logic [15:0] cmd_count;

    logic [7:0]  s_addr;
    logic [3:0]  s_page;
    logic [11:0] s_full_addr;
    logic        s_sel_in, s_sel_op1, s_sel_op2, s_sel_ram, s_esc_pending, s_addr_upd, s_page_upd;
    logic [3:0]  s_cmd_count;

    int errors = 0;
    int checks = 0;

    always #5 cmd_clk = ~cmd_clk;

    iv_cmd_decoder dut (
        .cmd_clk(cmd_clk), .rst(rst), .cmd_in(cmd_in),
        .addr(addr), .page(page), .full_addr(full_addr),
        .sel_in(sel_in), .sel_op1(sel_op1), .sel_op2(sel_op2), .sel_ram(sel_ram),
        .esc_pending(esc_pending), .addr_upd(addr_upd), .page_upd(page_upd),
        .cmd_count(cmd_count)
    );

    iv_cmd_decoder #(.CNT_W(4)) dut_sat (
        .cmd_clk(cmd_clk), .rst(rst), .cmd_in(cmd_in),
        .addr(s_addr), .page(s_page), .full_addr(s_full_addr),
        .sel_in(s_sel_in), .sel_op1(s_sel_op1), .sel_op2(s_sel_op2), .sel_ram(s_sel_ram),
        .esc_pending(s_esc_pending), .addr_upd(s_addr_upd), .page_upd(s_page_upd),
        .cmd_count(s_cmd_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte (and reset level) mid-cycle, then sample 1ns after the edge.
    task automatic step(input logic r, input logic [7:0] b);
        @(negedge cmd_clk);
        rst    = r;
        cmd_in = b;
        @(posedge cmd_clk);
        #1;
        $display("step rst=%0b cmd_in=%02h -> addr=%02h page=%0h esc=%0b au=%0b pu=%0b cnt=%0d",
                 r, b, addr, page, esc_pending, addr_upd, page_upd, cmd_count);
    endtask

    initial begin
        // Reset
        step(1'b1, 8'h00);
        chk("rst_addr", addr, 8'hFF);
        chk("rst_page", page, 4'h0);
        chk("rst_sel_in", sel_in, 1'b1);
        chk("rst_sel_op1", sel_op1, 1'b1);
        chk("rst_sel_op2", sel_op2, 1'b1);
        chk("rst_sel_ram", sel_ram, 1'b0);
        chk("rst_cnt", cmd_count, 16'd0);
        chk("rst_addr_upd", addr_upd, 1'b0);
        chk("rst_page_upd", page_upd, 1'b0);
        chk("rst_esc", esc_pending, 1'b0);

        // Plain address
        step(1'b0, 8'h17);
        chk("plain_addr", addr, 8'h17);
        chk("plain_sel_ram", sel_ram, 1'b1);
        chk("plain_sel_in", sel_in, 1'b0);
        chk("plain_sel_op1", sel_op1, 1'b0);
        chk("plain_sel_op2", sel_op2, 1'b0);
        chk("plain_addr_upd", addr_upd, 1'b1);
        chk("plain_cnt", cmd_count, 16'd1);

        // Page set: FE then 3A
        step(1'b0, 8'hFE);
        chk("pg_esc_pending", esc_pending, 1'b1);
        chk("pg_addr_hold", addr, 8'h17);
        chk("pg_addr_upd_one_cycle", addr_upd, 1'b0);
        chk("pg_no_page_upd", page_upd, 1'b0);
        step(1'b0, 8'h3A);
        chk("pg_page", page, 4'hA);
        chk("pg_full_addr", full_addr, 12'hA17);
        chk("pg_page_upd", page_upd, 1'b1);
        chk("pg_addr_upd", addr_upd, 1'b0);
        chk("pg_cnt", cmd_count, 16'd1);
        chk("pg_esc_clear", esc_pending, 1'b0);

        // Literal escape: FE, FE
        step(1'b0, 8'hFE);
        chk("lit_esc_pending", esc_pending, 1'b1);
        chk("lit_page_upd_one_cycle", page_upd, 1'b0);
        step(1'b0, 8'hFE);
        chk("lit_addr", addr, 8'hFE);
        chk("lit_sel_in", sel_in, 1'b1);
        chk("lit_sel_op1", sel_op1, 1'b1);
        chk("lit_sel_op2", sel_op2, 1'b1);
        chk("lit_sel_ram", sel_ram, 1'b0);
        chk("lit_addr_upd", addr_upd, 1'b1);
        chk("lit_page", page, 4'hA);
        chk("lit_esc", esc_pending, 1'b0);
        chk("lit_cnt", cmd_count, 16'd2);

        // Same-value reload
        step(1'b0, 8'h10);
        chk("re1_addr_upd", addr_upd, 1'b1);
        chk("re1_cnt", cmd_count, 16'd3);
        step(1'b0, 8'h10);
        chk("re2_addr", addr, 8'h10);
        chk("re2_addr_upd", addr_upd, 1'b1);
        chk("re2_cnt", cmd_count, 16'd4);

        // Reset mid-escape
        step(1'b0, 8'hFE);
        chk("rme_esc_pending", esc_pending, 1'b1);
        step(1'b1, 8'h05);
        chk("rme_addr", addr, 8'hFF);
        chk("rme_page", page, 4'h0);
        chk("rme_esc", esc_pending, 1'b0);
        chk("rme_page_upd", page_upd, 1'b0);
        chk("rme_cnt", cmd_count, 16'd0);
        step(1'b0, 8'h05);
        chk("rme_next_addr", addr, 8'h05);
        chk("rme_next_addr_upd", addr_upd, 1'b1);
        chk("rme_next_page", page, 4'h0);
        chk("rme_next_cnt", cmd_count, 16'd1);

        // Counter saturation on the CNT_W=4 instance
        step(1'b1, 8'h00);
        chk("sat_rst_cnt", s_cmd_count, 4'd0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'h20 + 8'(i);
            step(1'b0, b);
            chk($sformatf("sat_addr_%0d", i), s_addr, b);
            chk($sformatf("sat_addr_upd_%0d", i), s_addr_upd, 1'b1);
            chk($sformatf("sat_cnt_%0d", i), s_cmd_count, (i < 15) ? 4'(i + 1) : 4'hF);
            chk($sformatf("wide_cnt_%0d", i), cmd_count, 16'(i + 1));
        end
        chk("sat_final_cnt", s_cmd_count, 4'hF);
        chk("sat_final_addr", s_addr, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
